// File: rtl/apb_slave_mem.sv
// APB slave word memory: zero-wait APB slave with SETUP/ACCESS tracking,
// saturating transfer counters and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int unsigned SLAVE_ID = 0,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        prot_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_prdata;
    logic [15:0] r_wr_count;
    logic [15:0] r_rd_count;
    logic        r_prot_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_sel;
    logic        w_setup_req;
    logic        w_access_ok;
    logic [AW-1:0] w_lat_idx;
    logic        w_unused;

    assign w_sel       = psel[SLAVE_ID];
    assign w_setup_req = w_sel & ~penable;
    // The full byte address is latched so any change between SETUP and
    // ACCESS is caught; only the word-index bits select the memory word.
    assign w_access_ok = w_sel & penable & (paddr == r_addr) & (pwrite == r_write);
    assign w_lat_idx   = r_addr[AW+1:2];
    // Select lines of other slaves are intentionally ignored.
    assign w_unused    = ^psel;

    // Protocol FSM, read data register, counters and error flag
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_prdata   <= '0;
            r_wr_count <= '0;
            r_rd_count <= '0;
            r_prot_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup_req) begin
                        r_state <= S_SETUP;
                        r_addr  <= paddr;
                        r_write <= pwrite;
                    end else if (w_sel && penable) begin
                        r_prot_err <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_access_ok) begin
                        r_state <= S_ACCESS;
                        if (!r_write) begin
                            r_prdata <= r_mem[w_lat_idx];
                        end
                    end else begin
                        r_prot_err <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (r_write) begin
                        if (r_wr_count != 16'hFFFF) begin
                            r_wr_count <= r_wr_count + 16'd1;
                        end
                    end else begin
                        if (r_rd_count != 16'hFFFF) begin
                            r_rd_count <= r_rd_count + 16'd1;
                        end
                    end
                    if (w_setup_req) begin
                        r_state <= S_SETUP;
                        r_addr  <= paddr;
                        r_write <= pwrite;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory write at the closing edge of a write's ACCESS cycle; not reset,
    // and an async reset mid-ACCESS forces IDLE so the write is dropped.
    always_ff @(posedge hclk) begin
        if (r_state == S_ACCESS && r_write) begin
            r_mem[w_lat_idx] <= pwdata;
        end
    end

    assign prdata   = r_prdata;
    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;
    assign prot_err = r_prot_err;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed testbench for apb_slave_mem (SLAVE_ID=0, DEPTH=256).
module tb_apb_slave_mem;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic        prot_err;

    int total;
    int bad;

    apb_slave_mem #(
        .SLAVE_ID(0),
        .DEPTH   (256),
        .AW      (8)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .wr_count(wr_count),
        .rd_count(rd_count),
        .prot_err(prot_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Called at a falling edge; drives SETUP, then ACCESS, then returns at the
    // falling edge inside the slave's ACCESS state with prdata sampled.
    // pwdata is left untouched on reads so a preceding write still sees it.
    task automatic xfer(input logic [2:0] s, input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rd);
        psel    = s;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        if (w) pwdata = d;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        rd = prdata;
    endtask

    task automatic idle();
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge hclk);
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        #1;
        total++;
        if ({prdata, wr_count, rd_count, prot_err} !== 65'd0) begin
            bad++;
            $display("FAIL reset_values: got prdata=%h wr=%h rd=%h err=%b want all 0",
                     prdata, wr_count, rd_count, prot_err);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        xfer(3'b001, 32'h10, 1'b1, 32'hDEADBEEF, rd);
        idle();
        xfer(3'b001, 32'h10, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_read: got %h want deadbeef", rd);
        end
        idle();
        total++;
        if (wr_count !== 16'd1 || rd_count !== 16'd1) begin
            bad++;
            $display("FAIL basic_counts: got wr=%0d rd=%0d want wr=1 rd=1", wr_count, rd_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        xfer(3'b001, 32'h4, 1'b1, 32'h000000A5, rd);
        xfer(3'b001, 32'h4, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h000000A5) begin
            bad++;
            $display("FAIL b2b_raw: got %h want 000000a5", rd);
        end
        idle();
        total++;
        if (prot_err !== 1'b0 || wr_count !== 16'd2 || rd_count !== 16'd2) begin
            bad++;
            $display("FAIL b2b_state: got err=%b wr=%0d rd=%0d want err=0 wr=2 rd=2",
                     prot_err, wr_count, rd_count);
        end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        xfer(3'b001, 32'h400, 1'b1, 32'h12345678, rd);
        idle();
        xfer(3'b001, 32'h0, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h12345678) begin
            bad++;
            $display("FAIL alias_400: got %h want 12345678", rd);
        end
        idle();
        xfer(3'b001, 32'h3, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h12345678) begin
            bad++;
            $display("FAIL alias_byte3: got %h want 12345678", rd);
        end
        idle();
    endtask

    task automatic test_prot();
        logic [31:0] rd;
        do_reset();
        // ACCESS without SETUP
        psel    = 3'b001;
        penable = 1'b1;
        paddr   = 32'h20;
        pwrite  = 1'b1;
        pwdata  = 32'h77;
        @(negedge hclk);
        total++;
        if (prot_err !== 1'b1) begin
            bad++;
            $display("FAIL prot_no_setup: got err=%b want 1", prot_err);
        end
        idle();
        total++;
        if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
            bad++;
            $display("FAIL prot_counts: got wr=%0d rd=%0d want 0 0", wr_count, rd_count);
        end
        // SETUP followed by sel dropped
        do_reset();
        xfer(3'b001, 32'h30, 1'b1, 32'h11, rd);
        idle();
        total++;
        if (prot_err !== 1'b0) begin
            bad++;
            $display("FAIL prot_clean: got err=%b want 0", prot_err);
        end
        psel    = 3'b001;
        penable = 1'b0;
        paddr   = 32'h30;
        pwrite  = 1'b1;
        pwdata  = 32'h22;
        @(negedge hclk);
        psel = 3'b000;
        @(negedge hclk);
        total++;
        if (prot_err !== 1'b1) begin
            bad++;
            $display("FAIL prot_sel_drop: got err=%b want 1", prot_err);
        end
        xfer(3'b001, 32'h30, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h11) begin
            bad++;
            $display("FAIL prot_no_write: got %h want 00000011", rd);
        end
        idle();
        total++;
        if (wr_count !== 16'd1 || prot_err !== 1'b1) begin
            bad++;
            $display("FAIL prot_after: got wr=%0d err=%b want wr=1 err=1", wr_count, prot_err);
        end
    endtask

    task automatic test_other_slave();
        logic [31:0] rd;
        do_reset();
        xfer(3'b001, 32'h8, 1'b1, 32'h55, rd);
        idle();
        xfer(3'b010, 32'h8, 1'b1, 32'hFFFFFFFF, rd);
        idle();
        total++;
        if (wr_count !== 16'd1 || prot_err !== 1'b0) begin
            bad++;
            $display("FAIL other_counts: got wr=%0d err=%b want wr=1 err=0", wr_count, prot_err);
        end
        xfer(3'b001, 32'h8, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h55) begin
            bad++;
            $display("FAIL other_mem: got %h want 00000055", rd);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        xfer(3'b001, 32'h40, 1'b1, 32'h0000CAFE, rd);
        idle();
        xfer(3'b001, 32'h40, 1'b0, 32'h0, rd);
        idle();
        xfer(3'b001, 32'h40, 1'b1, 32'h00000BAD, rd);
        hresetn = 1'b0;
        #1;
        total++;
        if ({prdata, wr_count, rd_count, prot_err} !== 65'd0) begin
            bad++;
            $display("FAIL mid_async_reset: got prdata=%h wr=%h rd=%h err=%b want all 0",
                     prdata, wr_count, rd_count, prot_err);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        @(negedge hclk);
        xfer(3'b001, 32'h40, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h0000CAFE) begin
            bad++;
            $display("FAIL mid_write_dropped: got %h want 0000cafe", rd);
        end
        idle();
        total++;
        if (wr_count !== 16'd0 || rd_count !== 16'd1) begin
            bad++;
            $display("FAIL mid_counts: got wr=%0d rd=%0d want wr=0 rd=1", wr_count, rd_count);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd;
        force dut.r_wr_count = 16'hFFFF;
        #1;
        release dut.r_wr_count;
        xfer(3'b001, 32'h44, 1'b1, 32'h1, rd);
        idle();
        total++;
        if (wr_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL wr_saturate: got %h want ffff", wr_count);
        end
        xfer(3'b001, 32'h44, 1'b0, 32'h0, rd);
        total++;
        if (rd !== 32'h1) begin
            bad++;
            $display("FAIL sat_write_data: got %h want 00000001", rd);
        end
        idle();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        hresetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        paddr   = 32'h0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        @(negedge hclk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_alias();
        test_prot();
        test_other_slave();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
